// File: rtl/gardner_ted_param.sv
// rtl/gardner_ted_param.sv - Gardner timing error detector with parameterised half-symbol delay
//   clk_32M768        rising-edge clock
//   rst               synchronous active-high reset
//   in_valid          qualifies i_in/q_in/mode
//   i_in, q_in        signed WIDTH-bit samples
//   mode              0 = full Gardner, 1 = sign-based Gardner (travels with its sample)
//   err_out           saturated signed timing error, held between updates
//   err_valid         one-cycle strobe, 3 cycles after the triggering sample
//   err_sat           result was clipped (meaningful with err_valid, held otherwise)
module gardner_ted_param #(
    parameter int WIDTH      = 16,
    parameter int HALF_SYM   = 16,
    parameter int DIFF_BITS  = 8,
    parameter int PER_SAMPLE = 0
) (
    input  logic                    clk_32M768,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] i_in,
    input  logic signed [WIDTH-1:0] q_in,
    input  logic                    mode,
    output logic signed [WIDTH-1:0] err_out,
    output logic                    err_valid,
    output logic                    err_sat
);

    localparam int DEPTH = 2 * HALF_SYM;
    localparam int PTRW  = $clog2(DEPTH);
    localparam int FILLW = $clog2(DEPTH + 2);
    localparam int SH    = WIDTH + 1 - DIFF_BITS;
    localparam int PW    = WIDTH + DIFF_BITS;
    localparam int SW    = PW + 1;

    localparam logic [PTRW-1:0]  H_P     = PTRW'(HALF_SYM);
    localparam logic [PTRW-1:0]  LAST_P  = PTRW'(DEPTH - 1);
    localparam logic [FILLW-1:0] PRIME_F = FILLW'(DEPTH);
    localparam logic [FILLW-1:0] FULL_F  = FILLW'(DEPTH + 1);
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] line_i [DEPTH];
    logic signed [WIDTH-1:0] line_q [DEPTH];

    // The phase counter doubles as the delay-line write pointer: both count
    // valid samples modulo 2H from reset.
    logic [PTRW-1:0]  phase;
    logic [PTRW-1:0]  mid_ptr;
    logic [FILLW-1:0] fill;
    logic             compute;

    logic                        s1_valid, s1_mode;
    logic signed [WIDTH-1:0]     s1_mid_i, s1_mid_q;
    logic signed [DIFF_BITS-1:0] s1_op_i, s1_op_q;
    logic                        s2_valid, s2_mode;
    logic signed [PW-1:0]        s2_p_i, s2_p_q;
    logic signed [SW-1:0]        sum, res;
    logic                        sat_hi, sat_lo;
    logic signed [WIDTH-1:0]     sat_val;

    // Slot at phase still holds x[n-2H] until this sample overwrites it.
    assign mid_ptr = (phase >= H_P) ? phase - H_P : phase + H_P;
    assign compute = in_valid && (fill >= PRIME_F) &&
                     ((PER_SAMPLE != 0) || (phase == LAST_P));

    // Multiplier operand for mid: truncated late-early difference in full
    // mode, or (sgn(late)-sgn(early))/2 in simple mode, so one multiplier
    // serves both modes.
    function automatic logic signed [DIFF_BITS-1:0] mult_operand(
        input logic                    sel_simple,
        input logic signed [WIDTH-1:0] late,
        input logic signed [WIDTH-1:0] early
    );
        logic signed [WIDTH:0]       diff;
        logic signed [1:0]           step;
        logic signed [DIFF_BITS-1:0] step_x;
        logic signed [DIFF_BITS-1:0] diff_x;
        diff = ((WIDTH+1)'(late) - (WIDTH+1)'(early)) >>> SH;
        diff_x = DIFF_BITS'(diff);
        step = 2'sb00;
        if (!late[WIDTH-1] && early[WIDTH-1]) begin
            step = 2'sb01;
        end else if (late[WIDTH-1] && !early[WIDTH-1]) begin
            step = 2'sb11;
        end
        step_x = step;
        mult_operand = sel_simple ? step_x : diff_x;
    endfunction

    always_ff @(posedge clk_32M768) begin
        if (rst) begin
            phase <= '0;
            fill  <= '0;
        end else if (in_valid) begin
            phase <= (phase == LAST_P) ? '0 : phase + PTRW'(1);
            if (fill != FULL_F) begin
                fill <= fill + FILLW'(1);
            end
        end
    end

    always_ff @(posedge clk_32M768) begin
        if (!rst && in_valid) begin
            line_i[phase] <= i_in;
            line_q[phase] <= q_in;
        end
    end

    // Simple-mode sums are already integers; full-mode sums carry DIFF_BITS
    // fractional bits from the product scaling.
    always_comb begin
        sum    = SW'(s2_p_i) + SW'(s2_p_q);
        res    = s2_mode ? sum : (sum >>> DIFF_BITS);
        sat_hi = res > SAT_MAX;
        sat_lo = res < SAT_MIN;
        if (sat_hi) begin
            sat_val = SAT_MAX[WIDTH-1:0];
        end else if (sat_lo) begin
            sat_val = SAT_MIN[WIDTH-1:0];
        end else begin
            sat_val = res[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_32M768) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            err_valid <= 1'b0;
            err_out   <= '0;
            err_sat   <= 1'b0;
        end else begin
            s1_valid  <= compute;
            s2_valid  <= s1_valid;
            err_valid <= s2_valid;
            if (compute) begin
                s1_mode  <= mode;
                s1_mid_i <= line_i[mid_ptr];
                s1_mid_q <= line_q[mid_ptr];
                s1_op_i  <= mult_operand(mode, i_in, line_i[phase]);
                s1_op_q  <= mult_operand(mode, q_in, line_q[phase]);
            end
            if (s1_valid) begin
                s2_mode <= s1_mode;
                s2_p_i  <= PW'(s1_mid_i) * PW'(s1_op_i);
                s2_p_q  <= PW'(s1_mid_q) * PW'(s1_op_q);
            end
            if (s2_valid) begin
                err_out <= sat_val;
                err_sat <= sat_hi | sat_lo;
            end
        end
    end

endmodule

// File: tb/tb_gardner_ted_param.sv
// tb/tb_gardner_ted_param.sv - randomized model-checked bench for gardner_ted_param
module tb_gardner_ted_param;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] i_in;
    logic signed [15:0] q_in;
    logic               mode;
    logic signed [15:0] err_out0, err_out1;
    logic               err_valid0, err_valid1;
    logic               err_sat0, err_sat1;

    gardner_ted_param dut0 (
        .clk_32M768(clk), .rst(rst), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
        .mode(mode), .err_out(err_out0), .err_valid(err_valid0), .err_sat(err_sat0)
    );

    gardner_ted_param #(.WIDTH(16), .HALF_SYM(3), .DIFF_BITS(8), .PER_SAMPLE(1)) dut1 (
        .clk_32M768(clk), .rst(rst), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
        .mode(mode), .err_out(err_out1), .err_valid(err_valid1), .err_sat(err_sat1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int hist_i[$];
    int hist_q[$];
    bit pv[2][3];
    int po[2][3];
    bit ps[2][3];
    bit ev[2];
    int eo[2];
    bit es[2];

    function automatic int rnd();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int sgn(input int x);
        return (x >= 0) ? 1 : -1;
    endfunction

    // Gardner error from the three taps of I and Q, 16-bit samples, 8 kept diff bits.
    function automatic void ref_err(input bit md, input int li, input int mi, input int ei,
                                    input int lq, input int mq, input int eq,
                                    output int r, output bit sat);
        int raw;
        if (md) begin
            raw = mi * ((sgn(li) - sgn(ei)) / 2) + mq * ((sgn(lq) - sgn(eq)) / 2);
        end else begin
            raw = fdiv(mi * fdiv(li - ei, 512) + mq * fdiv(lq - eq, 512), 256);
        end
        sat = (raw > 32767) || (raw < -32768);
        r = (raw > 32767) ? 32767 : (raw < -32768) ? -32768 : raw;
    endfunction

    // Drive one clock of stimulus, advance the model, and leave ev/eo/es holding
    // what both DUTs must show #1 after this edge.
    task automatic step(input bit r, input bit v, input int iv, input int qv, input bit m);
        int n, h, rv;
        bit rs;
        rst = r; in_valid = v; i_in = 16'(iv); q_in = 16'(qv); mode = m;
        for (int d = 0; d < 2; d++) begin
            for (int k = 2; k > 0; k--) begin
                pv[d][k] = pv[d][k-1]; po[d][k] = po[d][k-1]; ps[d][k] = ps[d][k-1];
            end
            pv[d][0] = 1'b0;
        end
        if (r) begin
            for (int d = 0; d < 2; d++) for (int k = 0; k < 3; k++) pv[d][k] = 1'b0;
            hist_i.delete();
            hist_q.delete();
        end else if (v) begin
            n = hist_i.size();
            for (int d = 0; d < 2; d++) begin
                h = (d == 0) ? 16 : 3;
                if (n >= 2 * h && (d == 1 || (n % (2 * h)) == 2 * h - 1)) begin
                    ref_err(m, iv, hist_i[n-h], hist_i[n-2*h], qv, hist_q[n-h], hist_q[n-2*h], rv, rs);
                    pv[d][0] = 1'b1; po[d][0] = rv; ps[d][0] = rs;
                end
            end
            hist_i.push_back(iv);
            hist_q.push_back(qv);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            ev[d] = pv[d][2];
            if (r) begin
                eo[d] = 0; es[d] = 1'b0;
            end else if (pv[d][2]) begin
                eo[d] = po[d][2]; es[d] = ps[d][2];
            end
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 12345, -2222, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        checks++;
        if (err_valid0 !== 1'b0 || err_out0 !== 16'sd0 || err_sat0 !== 1'b0 ||
            err_valid1 !== 1'b0 || err_out1 !== 16'sd0 || err_sat1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got %0b/%0d/%0b %0b/%0d/%0b want 0/0/0 0/0/0",
                     err_valid0, err_out0, err_sat0, err_valid1, err_out1, err_sat1);
        end
    endtask

    task automatic test_steady();
        int first = -1;
        int prev = -1;
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 134; k++) begin
            step(1'b0, 1'b1, 1000, 0, 1'b0);
            checks++;
            if ({err_valid0, err_sat0, err_out0, err_valid1, err_sat1, err_out1} !==
                {ev[0], es[0], 16'(eo[0]), ev[1], es[1], 16'(eo[1])}) begin
                errors++;
                $display("FAIL steady_model cyc %0d got %0b/%0b/%0d %0b/%0b/%0d want %0b/%0b/%0d %0b/%0b/%0d",
                         cyc, err_valid0, err_sat0, err_out0, err_valid1, err_sat1, err_out1,
                         ev[0], es[0], eo[0], ev[1], es[1], eo[1]);
            end
            if (err_valid0 === 1'b1) begin
                checks++;
                if (err_out0 !== 16'sd0 || err_sat0 !== 1'b0) begin
                    errors++;
                    $display("FAIL steady_value got %0d/%0b want 0/0", err_out0, err_sat0);
                end
                if (first < 0) begin
                    first = k;
                end else begin
                    checks++;
                    if (k - prev != 32) begin
                        errors++;
                        $display("FAIL steady_gap got %0d want 32", k - prev);
                    end
                end
                prev = k;
            end
        end
        checks++;
        if (first != 65) begin
            errors++;
            $display("FAIL steady_first got %0d want 65", first);
        end
    endtask

    task automatic test_full_mode();
        int vi[66];
        int vq[66];
        int want_o;
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 1'b0, 0, 0, 1'b0);
            for (int k = 0; k < 66; k++) begin
                vi[k] = rnd();
                vq[k] = (c == 0) ? 0 : rnd();
            end
            if (c == 0) begin
                vi[31] = -16384; vi[47] = 8192; vi[63] = 16384;
                want_o = 2048;
            end else begin
                vi[31] = 32767;  vq[31] = 32767;
                vi[47] = -32768; vq[47] = -32768;
                vi[63] = -32768; vq[63] = -32768;
                want_o = 32767;
            end
            for (int k = 0; k < 66; k++) begin
                step(1'b0, 1'b1, vi[k], vq[k], 1'b0);
                checks++;
                if ({err_valid0, err_sat0, err_out0, err_valid1, err_sat1, err_out1} !==
                    {ev[0], es[0], 16'(eo[0]), ev[1], es[1], 16'(eo[1])}) begin
                    errors++;
                    $display("FAIL full_model cyc %0d got %0b/%0b/%0d %0b/%0b/%0d want %0b/%0b/%0d %0b/%0b/%0d",
                             cyc, err_valid0, err_sat0, err_out0, err_valid1, err_sat1, err_out1,
                             ev[0], es[0], eo[0], ev[1], es[1], eo[1]);
                end
            end
            checks++;
            if (err_valid0 !== 1'b1 || err_out0 !== 16'(want_o) || err_sat0 !== 1'(c)) begin
                errors++;
                $display("FAIL full_value case %0d got %0b/%0d/%0b want 1/%0d/%0d",
                         c, err_valid0, err_out0, err_sat0, want_o, c);
            end
        end
    endtask

    task automatic test_simple_toggle();
        int vi[66];
        int vq[66];
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 66; k++) begin
            vi[k] = rnd();
            vq[k] = rnd();
        end
        vi[31] = -100; vi[47] = 5000; vi[63] = 100;
        vq[31] = 0;    vq[47] = 0;    vq[63] = 0;
        for (int k = 0; k < 66; k++) begin
            step(1'b0, 1'b1, vi[k], vq[k], (k <= 63));
            checks++;
            if ({err_valid0, err_sat0, err_out0, err_valid1, err_sat1, err_out1} !==
                {ev[0], es[0], 16'(eo[0]), ev[1], es[1], 16'(eo[1])}) begin
                errors++;
                $display("FAIL simple_model cyc %0d got %0b/%0b/%0d %0b/%0b/%0d want %0b/%0b/%0d %0b/%0b/%0d",
                         cyc, err_valid0, err_sat0, err_out0, err_valid1, err_sat1, err_out1,
                         ev[0], es[0], eo[0], ev[1], es[1], eo[1]);
            end
        end
        checks++;
        if (err_valid0 !== 1'b1 || err_out0 !== 16'sd5000 || err_sat0 !== 1'b0) begin
            errors++;
            $display("FAIL simple_value got %0b/%0d/%0b want 1/5000/0", err_valid0, err_out0, err_sat0);
        end
    endtask

    task automatic test_gaps();
        int nv = 0;
        int seen1 = 0;
        bit v;
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 403; k++) begin
            if (k >= 400) v = 1'b0;
            else if (k < 200) v = (k % 2 == 0);
            else v = 1'($urandom_range(1));
            step(1'b0, v, rnd(), rnd(), 1'($urandom_range(1)));
            if (v) nv++;
            if (err_valid1 === 1'b1) seen1++;
            checks++;
            if ({err_valid0, err_sat0, err_out0, err_valid1, err_sat1, err_out1} !==
                {ev[0], es[0], 16'(eo[0]), ev[1], es[1], 16'(eo[1])}) begin
                errors++;
                $display("FAIL gaps_model cyc %0d got %0b/%0b/%0d %0b/%0b/%0d want %0b/%0b/%0d %0b/%0b/%0d",
                         cyc, err_valid0, err_sat0, err_out0, err_valid1, err_sat1, err_out1,
                         ev[0], es[0], eo[0], ev[1], es[1], eo[1]);
            end
        end
        checks++;
        if (seen1 != nv - 6) begin
            errors++;
            $display("FAIL gaps_strobe_count got %0d want %0d", seen1, nv - 6);
        end
    endtask

    task automatic test_reset_mid();
        int first1 = -1;
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 64; k++) begin
            step(1'b0, 1'b1, rnd(), rnd(), 1'b0);
        end
        step(1'b1, 1'b1, rnd(), rnd(), 1'b0);
        checks++;
        if (err_valid0 !== 1'b0 || err_out0 !== 16'sd0 || err_sat0 !== 1'b0 ||
            err_valid1 !== 1'b0 || err_out1 !== 16'sd0 || err_sat1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %0b/%0d/%0b %0b/%0d/%0b want 0/0/0 0/0/0",
                     err_valid0, err_out0, err_sat0, err_valid1, err_out1, err_sat1);
        end
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, rnd(), rnd(), 1'($urandom_range(1)));
            if (err_valid1 === 1'b1 && first1 < 0) first1 = k;
            checks++;
            if ({err_valid0, err_sat0, err_out0, err_valid1, err_sat1, err_out1} !==
                {ev[0], es[0], 16'(eo[0]), ev[1], es[1], 16'(eo[1])}) begin
                errors++;
                $display("FAIL reset_mid_model cyc %0d got %0b/%0b/%0d %0b/%0b/%0d want %0b/%0b/%0d %0b/%0b/%0d",
                         cyc, err_valid0, err_sat0, err_out0, err_valid1, err_sat1, err_out1,
                         ev[0], es[0], eo[0], ev[1], es[1], eo[1]);
            end
        end
        checks++;
        if (first1 != 8) begin
            errors++;
            $display("FAIL reset_mid_reprime got %0d want 8", first1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; i_in = '0; q_in = '0; mode = 1'b0;
        test_reset();
        test_steady();
        test_full_mode();
        test_simple_toggle();
        test_gaps();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
